// File: rtl/ldm_stm_addr_seq.sv
// Sequential word-address generator for ARM LDM/STM block transfers.
// Latches base/list/mode on launch, emits one address per accepted handshake, then reports writeback.
module ldm_stm_addr_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int WORD_BYTES = 4,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  start_in,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic [NUM_REGS-1:0]   reg_list_in,
  input  logic                  pre_in,
  input  logic                  up_in,
  input  logic                  wb_in,
  input  logic                  mem_ready_in,
  output logic                  busy_out,
  output logic                  addr_valid_out,
  output logic [ADDR_WIDTH-1:0] addr_to_mem_out,
  output logic [IDX_W-1:0]      reg_idx_out,
  output logic                  last_out,
  output logic                  done_out,
  output logic                  wb_en_out,
  output logic [ADDR_WIDTH-1:0] data_to_reg_update_out
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [NUM_REGS-1:0]   MASK_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, m[i]};
    end
    return c;
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_REGS-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t                state_q, state_d;
  logic [NUM_REGS-1:0]   mask_q, mask_d;
  logic                  wbp_q, wbp_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  wb_en_q, wb_en_d;
  logic [ADDR_WIDTH-1:0] data_q, data_d;

  logic [CNT_W-1:0]      n_s;
  logic [ADDR_WIDTH-1:0] off_s;
  logic [ADDR_WIDTH-1:0] start_addr_s;
  logic [ADDR_WIDTH-1:0] wb_val_s;
  logic [NUM_REGS-1:0]   mask_rest_s;

  always_comb begin
    n_s         = popcount(reg_list_in);
    off_s       = ADDR_WIDTH'(n_s) * STRIDE;
    mask_rest_s = mask_q & (mask_q - MASK_ONE);
    wb_val_s    = up_in ? (base_addr_in + off_s) : (base_addr_in - off_s);
    case ({pre_in, up_in})
      2'b01:   start_addr_s = base_addr_in;
      2'b11:   start_addr_s = base_addr_in + STRIDE;
      2'b00:   start_addr_s = base_addr_in - off_s + STRIDE;
      2'b10:   start_addr_s = base_addr_in - off_s;
      default: start_addr_s = base_addr_in;
    endcase

    state_d = state_q;
    mask_d  = mask_q;
    wbp_d   = wbp_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    wb_en_d = 1'b0;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          mask_d  = reg_list_in;
          wbp_d   = wb_in && (n_s != '0);
          addr_d  = start_addr_s;
          idx_d   = lowest_idx(reg_list_in);
          last_d  = (n_s == {{(CNT_W-1){1'b0}}, 1'b1});
          data_d  = wb_val_s;
          busy_d  = 1'b1;
          if (n_s != '0) begin
            state_d = ST_XFER;
            valid_d = 1'b1;
          end else begin
            // Empty list: straight to completion, never a writeback
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (mem_ready_in) begin
          mask_d = mask_rest_s;
          addr_d = addr_q + STRIDE;
          if (last_q) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            wb_en_d = wbp_q;
          end else begin
            idx_d  = lowest_idx(mask_rest_s);
            last_d = ((mask_rest_s & (mask_rest_s - MASK_ONE)) == '0);
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer without a completion pulse
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      wbp_q   <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      wb_en_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wbp_q   <= wbp_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      wb_en_q <= wb_en_d;
      data_q  <= data_d;
    end
  end

  assign busy_out               = busy_q;
  assign addr_valid_out         = valid_q;
  assign addr_to_mem_out        = addr_q;
  assign reg_idx_out            = idx_q;
  assign last_out               = last_q;
  assign done_out               = done_q;
  assign wb_en_out              = wb_en_q;
  assign data_to_reg_update_out = data_q;

endmodule

// File: tb/tb_ldm_stm_addr_seq.sv
// Self-checking bench for ldm_stm_addr_seq: vector table of block transfers plus
// hand-written stall, empty-list, DONE-cycle start and mid-transfer reset sequences.
module tb_ldm_stm_addr_seq;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [31:0] base_addr_in;
  logic [15:0] reg_list_in;
  logic        pre_in, up_in, wb_in;
  logic        mem_ready_in;
  logic        busy_out, addr_valid_out, last_out, done_out, wb_en_out;
  logic [31:0] addr_to_mem_out;
  logic [3:0]  reg_idx_out;
  logic [31:0] data_to_reg_update_out;

  ldm_stm_addr_seq #(.ADDR_WIDTH(32), .NUM_REGS(16), .WORD_BYTES(4)) dut (
    .clk_in                 (clk_in),
    .reset_in               (reset_in),
    .start_in               (start_in),
    .base_addr_in           (base_addr_in),
    .reg_list_in            (reg_list_in),
    .pre_in                 (pre_in),
    .up_in                  (up_in),
    .wb_in                  (wb_in),
    .mem_ready_in           (mem_ready_in),
    .busy_out               (busy_out),
    .addr_valid_out         (addr_valid_out),
    .addr_to_mem_out        (addr_to_mem_out),
    .reg_idx_out            (reg_idx_out),
    .last_out               (last_out),
    .done_out               (done_out),
    .wb_en_out              (wb_en_out),
    .data_to_reg_update_out (data_to_reg_update_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] base;
    logic [15:0] list;
    logic        p, u, w;
    logic [31:0] first;
    logic [31:0] wbd;
    logic        wbe;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  idx;
    logic        last;
  } xfer_t;

  typedef struct {
    logic        wbe;
    logic [31:0] data;
  } done_t;

  xfer_t exp_q[$];
  done_t done_q[$];
  vec_t  tbl[8];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: pop on accepted transfer / completion, compare held values while stalled
  always @(negedge clk_in) begin
    if (addr_valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_xfer", 32'd1, 32'd0);
      end else if (mem_ready_in) begin
        xfer_t e;
        e = exp_q.pop_front();
        chk("xfer_addr", addr_to_mem_out, e.addr);
        chk("xfer_idx", {28'd0, reg_idx_out}, {28'd0, e.idx});
        chk("xfer_last", {31'd0, last_out}, {31'd0, e.last});
        chk("xfer_busy", {31'd0, busy_out}, 32'd1);
      end else begin
        chk("stall_addr", addr_to_mem_out, exp_q[0].addr);
        chk("stall_idx", {28'd0, reg_idx_out}, {28'd0, exp_q[0].idx});
      end
    end
    if (done_out) begin
      if (done_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        done_t d;
        d = done_q.pop_front();
        chk("done_wb_en", {31'd0, wb_en_out}, {31'd0, d.wbe});
        chk("done_data", data_to_reg_update_out, d.data);
        chk("done_no_valid", {31'd0, addr_valid_out}, 32'd0);
      end
    end
  end

  task automatic launch(input vec_t v);
    int n;
    int k;
    n = 0;
    for (int i = 0; i < 16; i++) n += int'(v.list[i]);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (v.list[i]) begin
        exp_q.push_back('{addr: v.first + 32'(k) * 32'd4, idx: 4'(i), last: (k == n - 1)});
        k++;
      end
    end
    done_q.push_back('{wbe: v.wbe, data: v.wbd});
    @(posedge clk_in); #1;
    start_in = 1'b1; base_addr_in = v.base; reg_list_in = v.list;
    pre_in = v.p; up_in = v.u; wb_in = v.w;
    @(posedge clk_in); #1;
    start_in = 1'b0; base_addr_in = $urandom; reg_list_in = 16'($urandom);
    pre_in = 1'($urandom); up_in = 1'($urandom); wb_in = 1'($urandom);
    @(negedge clk_in);
    chk("launch_busy", {31'd0, busy_out}, 32'd1);
    chk("launch_valid", {31'd0, addr_valid_out}, (n != 0) ? 32'd1 : 32'd0);
    chk("launch_done", {31'd0, done_out}, (n == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic wait_done(input logic [31:0] wbd, input bit poke_start);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (done_out) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_in);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (poke_start) begin
      start_in = 1'b1; reg_list_in = 16'h000F; base_addr_in = 32'h0000_7000;
    end
    @(posedge clk_in); #1;
    start_in = 1'b0;
    @(negedge clk_in);
    chk("post_done_pulse", {31'd0, done_out}, 32'd0);
    chk("post_busy", {31'd0, busy_out}, 32'd0);
    chk("post_valid", {31'd0, addr_valid_out}, 32'd0);
    chk("post_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("data_hold", data_to_reg_update_out, wbd);
  endtask

  initial begin
    vec_t v;
    //          base          list      p     u     w     first         wbdata        wbe
    tbl[0] = '{32'h0000_1000, 16'h000B, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 32'h0000_100C, 1'b1};
    tbl[1] = '{32'h0000_2000, 16'h8001, 1'b1, 1'b0, 1'b1, 32'h0000_1FF8, 32'h0000_1FF8, 1'b1};
    tbl[2] = '{32'h0000_2000, 16'h8001, 1'b1, 1'b1, 1'b1, 32'h0000_2004, 32'h0000_2008, 1'b1};
    tbl[3] = '{32'h0000_2000, 16'h8001, 1'b0, 1'b0, 1'b1, 32'h0000_1FFC, 32'h0000_1FF8, 1'b1};
    tbl[4] = '{32'hFFFF_FFFC, 16'h0003, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0004, 1'b1};
    tbl[5] = '{32'h0000_0500, 16'h0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0500, 1'b0};
    tbl[6] = '{32'h0000_0040, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[7] = '{32'h0000_0010, 16'h8000, 1'b1, 1'b1, 1'b1, 32'h0000_0014, 32'h0000_0014, 1'b1};

    reset_in = 1'b1; start_in = 1'b0; base_addr_in = 32'h0; reg_list_in = 16'h0;
    pre_in = 1'b0; up_in = 1'b0; wb_in = 1'b0; mem_ready_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_busy", {31'd0, busy_out}, 32'd0);
    chk("rst_valid", {31'd0, addr_valid_out}, 32'd0);
    chk("rst_last", {31'd0, last_out}, 32'd0);
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en_out}, 32'd0);
    chk("rst_addr", addr_to_mem_out, 32'd0);
    chk("rst_idx", {28'd0, reg_idx_out}, 32'd0);
    chk("rst_data", data_to_reg_update_out, 32'd0);
    @(posedge clk_in); #1;
    reset_in = 1'b0;

    for (int t = 0; t < 8; t++) begin
      launch(tbl[t]);
      wait_done(tbl[t].wbd, 1'b0);
    end

    // Stall: first transfer held for three cycles with ready low
    mem_ready_in = 1'b0;
    v = '{32'h0000_0100, 16'h0006, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0108, 1'b1};
    launch(v);
    chk("stall_addr0", addr_to_mem_out, 32'h0000_0100);
    chk("stall_idx0", {28'd0, reg_idx_out}, 32'd1);
    repeat (3) @(posedge clk_in);
    #1 mem_ready_in = 1'b1;
    wait_done(32'h0000_0108, 1'b0);

    // start_in during the DONE cycle is ignored
    launch(tbl[0]);
    wait_done(tbl[0].wbd, 1'b1);

    // Reset after two accepted transfers abandons the operation
    v = '{32'h0000_0300, 16'h00FF, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0000_0320, 1'b1};
    launch(v);
    @(posedge clk_in);
    @(posedge clk_in); #1;
    mem_ready_in = 1'b0;
    reset_in = 1'b1;
    @(posedge clk_in); #1;
    reset_in = 1'b0;
    exp_q.delete();
    done_q.delete();
    @(negedge clk_in);
    chk("abort_busy", {31'd0, busy_out}, 32'd0);
    chk("abort_valid", {31'd0, addr_valid_out}, 32'd0);
    chk("abort_done", {31'd0, done_out}, 32'd0);
    chk("abort_wb_en", {31'd0, wb_en_out}, 32'd0);
    chk("abort_addr", addr_to_mem_out, 32'd0);
    chk("abort_idx", {28'd0, reg_idx_out}, 32'd0);
    chk("abort_last", {31'd0, last_out}, 32'd0);
    chk("abort_data", data_to_reg_update_out, 32'd0);
    repeat (3) begin
      @(negedge clk_in);
      chk("abort_no_done", {31'd0, done_out}, 32'd0);
    end
    mem_ready_in = 1'b1;
    launch(tbl[0]);
    wait_done(tbl[0].wbd, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
